// File: rtl/axi_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_wr_arbiter_if
//  Purpose  : AXI4 write-channel bundle (AW, W, B) shared by requesters and memory
//  Revision : 1.0  initial release
// ============================================================================
interface axi_wr_arbiter_if #(
   parameter int DW = 512
);
   logic [63:0]     awaddr;
   logic [7:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;
   logic            awvalid;
   logic            awready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wlast;
   logic            wvalid;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;

   modport master (
      output awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready
   );

   modport slave (
      input  awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready
   );
endinterface
`default_nettype wire

// File: rtl/axi_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axi_wr_arbiter
//  Purpose  : Two-requester AXI4 write arbiter, round-robin burst grants with
//             W/B steering in grant order through two ordering FIFOs
//  Revision : 1.0  initial release
// ============================================================================
module axi_wr_arbiter #(
   parameter int DW          = 512,
   parameter int ORDER_DEPTH = 16
) (
   input  logic                          ram_clk,
   input  logic                          ram_reset,
   axi_wr_arbiter_if.slave               s0_axi,
   axi_wr_arbiter_if.slave               s1_axi,
   axi_wr_arbiter_if.master              m_axi,
   output logic [3:0]                    m_axi_awid,
   output logic                          m_axi_awlock,
   output logic [3:0]                    m_axi_awcache,
   output logic [3:0]                    m_axi_awqos,
   output logic [2:0]                    m_axi_awprot,
   output logic [$clog2(ORDER_DEPTH):0]  outstanding,
   output logic                          b_orphan
);

   localparam int c_PTR_W = $clog2(ORDER_DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam int c_W_ORD = 0;
   localparam int c_B_ORD = 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } aw_state_t;

   aw_state_t           r_state;
   aw_state_t           w_state_nxt;
   logic                r_last_grant;
   logic [63:0]         r_awaddr;
   logic [7:0]          r_awlen;
   logic [2:0]          r_awsize;
   logic [1:0]          r_awburst;
   logic                r_b_orphan;

   logic                r_ord_mem [2][ORDER_DEPTH];
   logic [c_PTR_W-1:0]  r_wr_ptr  [2];
   logic [c_PTR_W-1:0]  r_rd_ptr  [2];
   logic [c_CNT_W-1:0]  r_count   [2];

   logic                w_accept;
   logic                w_grant_sel;
   logic                w_any_valid;
   logic                w_full_any;
   logic [1:0]          w_pop;
   logic [1:0]          w_head;
   logic [1:0]          w_nonempty;
   logic [DW-1:0]       w_wdata;
   logic [DW/8-1:0]     w_wstrb;

   assign w_nonempty[c_W_ORD] = (r_count[c_W_ORD] != '0);
   assign w_nonempty[c_B_ORD] = (r_count[c_B_ORD] != '0);
   assign w_head[c_W_ORD]     = r_ord_mem[c_W_ORD][r_rd_ptr[c_W_ORD]];
   assign w_head[c_B_ORD]     = r_ord_mem[c_B_ORD][r_rd_ptr[c_B_ORD]];
   assign w_full_any          = (r_count[c_W_ORD] == c_CNT_W'(ORDER_DEPTH)) ||
                                (r_count[c_B_ORD] == c_CNT_W'(ORDER_DEPTH));

   // Requester not granted last wins a tie; otherwise the lone valid one.
   assign w_any_valid = s0_axi.awvalid | s1_axi.awvalid;
   assign w_grant_sel = (s0_axi.awvalid && s1_axi.awvalid) ? ~r_last_grant : s1_axi.awvalid;

   // ---------------------------------------------------------------- AW FSM
   always_ff @(posedge ram_clk) begin
      if (ram_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any_valid && !w_full_any) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (m_axi.awready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge ram_clk) begin
      if (ram_reset) begin
         r_last_grant <= 1'b1;
         r_awaddr     <= '0;
         r_awlen      <= '0;
         r_awsize     <= '0;
         r_awburst    <= '0;
      end else if (w_accept) begin
         r_last_grant <= w_grant_sel;
         r_awaddr     <= w_grant_sel ? s1_axi.awaddr  : s0_axi.awaddr;
         r_awlen      <= w_grant_sel ? s1_axi.awlen   : s0_axi.awlen;
         r_awsize     <= w_grant_sel ? s1_axi.awsize  : s0_axi.awsize;
         r_awburst    <= w_grant_sel ? s1_axi.awburst : s0_axi.awburst;
      end
   end

   assign s0_axi.awready = w_accept & ~w_grant_sel;
   assign s1_axi.awready = w_accept &  w_grant_sel;

   assign m_axi.awvalid  = (r_state == ST_HOLD);
   assign m_axi.awaddr   = r_awaddr;
   assign m_axi.awlen    = r_awlen;
   assign m_axi.awsize   = r_awsize;
   assign m_axi.awburst  = r_awburst;

   assign m_axi_awid     = '0;
   assign m_axi_awlock   = 1'b0;
   assign m_axi_awcache  = '0;
   assign m_axi_awqos    = '0;
   assign m_axi_awprot   = '0;

   // ------------------------------------------------- ordering FIFOs (W, B)
   // Both FIFOs take the granted requester index on every AW acceptance.
   always_ff @(posedge ram_clk) begin
      for (int f = 0; f < 2; f++) begin
         if (ram_reset) begin
            r_wr_ptr[f] <= '0;
            r_rd_ptr[f] <= '0;
            r_count[f]  <= '0;
         end else begin
            if (w_accept) begin
               r_ord_mem[f][r_wr_ptr[f]] <= w_grant_sel;
               r_wr_ptr[f]               <= r_wr_ptr[f] + c_PTR_W'(1);
            end
            if (w_pop[f]) begin
               r_rd_ptr[f] <= r_rd_ptr[f] + c_PTR_W'(1);
            end
            if (w_accept && !w_pop[f]) begin
               r_count[f] <= r_count[f] + c_CNT_W'(1);
            end else if (!w_accept && w_pop[f]) begin
               r_count[f] <= r_count[f] - c_CNT_W'(1);
            end
         end
      end
   end

   // -------------------------------------------------------- W steering
   always_comb begin
      w_wdata        = '0;
      w_wstrb        = '0;
      m_axi.wlast    = 1'b0;
      m_axi.wvalid   = 1'b0;
      s0_axi.wready  = 1'b0;
      s1_axi.wready  = 1'b0;
      if (w_nonempty[c_W_ORD]) begin
         if (w_head[c_W_ORD]) begin
            w_wdata       = s1_axi.wdata;
            w_wstrb       = s1_axi.wstrb;
            m_axi.wlast   = s1_axi.wlast;
            m_axi.wvalid  = s1_axi.wvalid;
            s1_axi.wready = m_axi.wready;
         end else begin
            w_wdata       = s0_axi.wdata;
            w_wstrb       = s0_axi.wstrb;
            m_axi.wlast   = s0_axi.wlast;
            m_axi.wvalid  = s0_axi.wvalid;
            s0_axi.wready = m_axi.wready;
         end
      end
   end

   assign m_axi.wdata   = w_wdata;
   assign m_axi.wstrb   = w_wstrb;
   assign w_pop[c_W_ORD] = m_axi.wvalid & m_axi.wready & m_axi.wlast;

   // -------------------------------------------------------- B steering
   // With nothing outstanding the memory's B channel is drained and flagged.
   always_comb begin
      s0_axi.bvalid = 1'b0;
      s1_axi.bvalid = 1'b0;
      s0_axi.bresp  = '0;
      s1_axi.bresp  = '0;
      m_axi.bready  = 1'b1;
      if (w_nonempty[c_B_ORD]) begin
         if (w_head[c_B_ORD]) begin
            s1_axi.bvalid = m_axi.bvalid;
            s1_axi.bresp  = m_axi.bresp;
            m_axi.bready  = s1_axi.bready;
         end else begin
            s0_axi.bvalid = m_axi.bvalid;
            s0_axi.bresp  = m_axi.bresp;
            m_axi.bready  = s0_axi.bready;
         end
      end
   end

   assign w_pop[c_B_ORD] = w_nonempty[c_B_ORD] & m_axi.bvalid & m_axi.bready;

   always_ff @(posedge ram_clk) begin
      if (ram_reset) begin
         r_b_orphan <= 1'b0;
      end else if (!w_nonempty[c_B_ORD] && m_axi.bvalid) begin
         r_b_orphan <= 1'b1;
      end
   end

   assign b_orphan    = r_b_orphan;
   // B-FIFO occupancy is exactly bursts granted minus B responses popped.
   assign outstanding = r_count[c_B_ORD];

endmodule
`default_nettype wire
